bsg_arb_weighted_rr: RTL and testbench

BSG_ARB_WEIGHTED_RR -- requirements
Module: bsg_arb_weighted_rr

---
 rtl/bsg_arb_pkg.sv | 27 ++
 rtl/bsg_arb_rr_pick.sv | 38 +++
 rtl/bsg_arb_weighted_rr.sv | 118 +++++++++++
 tb/tb_bsg_arb_weighted_rr.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_arb_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter.
package bsg_arb_pkg;

    localparam int unsigned MAX_REQS      = 32;
    localparam int unsigned MAX_WEIGHT_W  = 16;
    localparam int unsigned MAX_WEIGHTS_W = MAX_REQS * MAX_WEIGHT_W;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Extract weight field idx from a packed vector of weight_w-wide fields.
    function automatic logic [MAX_WEIGHT_W-1:0] unpack_weight(
        input logic [MAX_WEIGHTS_W-1:0] weights,
        input int unsigned              idx,
        input int unsigned              weight_w
    );
        logic [MAX_WEIGHT_W-1:0] mask;
        mask = (MAX_WEIGHT_W'(1) << weight_w) - MAX_WEIGHT_W'(1);
        if (weight_w >= MAX_WEIGHT_W) begin
            mask = '1;
        end
        return MAX_WEIGHT_W'(weights >> (idx * weight_w)) & mask;
    endfunction

endpackage

// File: rtl/bsg_arb_rr_pick.sv
// Rotating first-one finder: first set request at or after start_i, wrapping.
module bsg_arb_rr_pick
    import bsg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned ID_W     = idx_width(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] reqs_i,
    input  logic [ID_W-1:0]     start_i,
    output logic [NUM_REQS-1:0] one_hot_o,
    output logic [ID_W-1:0]     id_o,
    output logic                v_o
);

    logic [ID_W:0] w_k;

    // Scan from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        w_k       = '0;
        id_o      = '0;
        v_o       = 1'b0;
        one_hot_o = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            w_k = {1'b0, start_i} + (ID_W+1)'(i);
            if (w_k >= (ID_W+1)'(NUM_REQS)) begin
                w_k = w_k - (ID_W+1)'(NUM_REQS);
            end
            if (reqs_i[w_k[ID_W-1:0]]) begin
                id_o = w_k[ID_W-1:0];
                v_o  = 1'b1;
            end
        end
        if (v_o) begin
            one_hot_o = NUM_REQS'(1) << id_o;
        end
    end

endmodule

// File: rtl/bsg_arb_weighted_rr.sv
// Weighted round-robin arbiter: a granted requester keeps the grant for up to
// its weight in handshakes, then priority rotates past it.
module bsg_arb_weighted_rr
    import bsg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned WEIGHT_W = 4,
    localparam int unsigned ID_W    = idx_width(NUM_REQS)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [NUM_REQS-1:0]          reqs_i,
    input  logic [NUM_REQS*WEIGHT_W-1:0] weights_i,
    input  logic                         yumi_i,
    output logic [NUM_REQS-1:0]          grants_o,
    output logic [ID_W-1:0]              grant_id_o,
    output logic                         v_o
);

    logic [ID_W-1:0]     last_r,  w_last_nxt;
    logic                own_v_r, w_own_v_nxt;
    logic [ID_W-1:0]     own_r,   w_own_nxt;
    logic [WEIGHT_W-1:0] cnt_r,   w_cnt_nxt;
    logic [WEIGHT_W-1:0] wt_r,    w_wt_nxt;

    logic [ID_W-1:0]     w_start;
    logic [NUM_REQS-1:0] w_pick_oh;
    logic [ID_W-1:0]     w_pick_id;
    logic                w_pick_v;
    logic                w_own_req;
    logic                w_own_hit;
    logic                w_hs;
    logic [WEIGHT_W-1:0] w_raw_wt;
    logic [WEIGHT_W-1:0] w_eff_wt;
    logic [WEIGHT_W-1:0] w_cnt_inc;

    assign w_start = (last_r == ID_W'(NUM_REQS - 1)) ? '0 : last_r + ID_W'(1);

    bsg_arb_rr_pick #(
        .NUM_REQS (NUM_REQS),
        .ID_W     (ID_W)
    ) u_pick (
        .reqs_i    (reqs_i),
        .start_i   (w_start),
        .one_hot_o (w_pick_oh),
        .id_o      (w_pick_id),
        .v_o       (w_pick_v)
    );

    // Grant outputs: an active owner that still requests wins over rotation.
    always_comb begin
        w_own_req  = reqs_i[own_r];
        w_own_hit  = own_v_r & w_own_req;
        v_o        = w_pick_v;
        grant_id_o = w_pick_id;
        grants_o   = w_pick_oh;
        if (w_own_hit) begin
            grant_id_o = own_r;
            grants_o   = NUM_REQS'(1) << own_r;
        end
    end

    assign w_hs      = v_o & yumi_i;
    assign w_raw_wt  = WEIGHT_W'(unpack_weight(MAX_WEIGHTS_W'(weights_i), 32'(w_pick_id), WEIGHT_W));
    assign w_eff_wt  = (w_raw_wt == '0) ? WEIGHT_W'(1) : w_raw_wt;
    assign w_cnt_inc = cnt_r + WEIGHT_W'(1);

    // Next state: owner drop first, then handshake (a new turn overrides it).
    always_comb begin
        w_last_nxt  = last_r;
        w_own_v_nxt = own_v_r;
        w_own_nxt   = own_r;
        w_cnt_nxt   = cnt_r;
        w_wt_nxt    = wt_r;

        if (own_v_r && !w_own_req) begin
            w_own_v_nxt = 1'b0;
            w_last_nxt  = own_r;
        end

        if (w_hs) begin
            if (w_own_hit) begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == wt_r) begin
                    w_own_v_nxt = 1'b0;
                    w_last_nxt  = own_r;
                end
            end else begin
                w_wt_nxt  = w_eff_wt;
                w_cnt_nxt = WEIGHT_W'(1);
                if (w_eff_wt > WEIGHT_W'(1)) begin
                    w_own_v_nxt = 1'b1;
                    w_own_nxt   = w_pick_id;
                end else begin
                    w_own_v_nxt = 1'b0;
                    w_last_nxt  = w_pick_id;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            last_r  <= ID_W'(NUM_REQS - 1);
            own_v_r <= 1'b0;
            own_r   <= '0;
            cnt_r   <= '0;
            wt_r    <= '0;
        end else begin
            last_r  <= w_last_nxt;
            own_v_r <= w_own_v_nxt;
            own_r   <= w_own_nxt;
            cnt_r   <= w_cnt_nxt;
            wt_r    <= w_wt_nxt;
        end
    end

endmodule

// File: tb/tb_bsg_arb_weighted_rr.sv
// Scoreboard bench for bsg_arb_weighted_rr: directed vectors with expected grants.
module tb_bsg_arb_weighted_rr;

    localparam int unsigned N     = 4;
    localparam int unsigned WW    = 4;
    localparam int unsigned IDW   = 2;
    localparam int          BOUND = (N - 1) * ((1 << WW) - 1);

    typedef struct {
        logic           v;
        logic [IDW-1:0] id;
        string          name;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      reqs = '0;
    logic [N*WW-1:0]   weights = '0;
    logic              yumi = 1'b0;
    logic [N-1:0]      grants;
    logic [IDW-1:0]    grant_id;
    logic              v;

    logic [N*WW-1:0]   cur_w = '0;
    exp_t              sb_q[$];
    exp_t              mon_e;
    logic [N-1:0]      mon_g;
    int                n_tests = 0;
    int                n_fail = 0;
    int                wait_cnt [N];

    always #5 clk = ~clk;

    bsg_arb_weighted_rr #(
        .NUM_REQS (N),
        .WEIGHT_W (WW)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .reqs_i     (reqs),
        .weights_i  (weights),
        .yumi_i     (yumi),
        .grants_o   (grants),
        .grant_id_o (grant_id),
        .v_o        (v)
    );

    // eid >= 0: expect grant eid; -1: expect no grant; -2: no check this cycle.
    task automatic drive(input logic rst_n, input logic [N-1:0] rq, input logic yu,
                         input int eid, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rst_n;
        reqs    = rq;
        weights = cur_w;
        yumi    = yu;
        if (eid != -2) begin
            e.v    = (eid >= 0);
            e.id   = (eid >= 0) ? IDW'(eid) : '0;
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b1111, 1'b1, -2, "rst_enter");
        drive(1'b0, 4'b1111, 1'b1, 0, "rst_hold");
    endtask

    // Monitor: pops the expectation for this cycle and checks invariants.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_g = mon_e.v ? (N'(1) << mon_e.id) : '0;
            n_tests++;
            if (v !== mon_e.v || grant_id !== mon_e.id || grants !== mon_g) begin
                n_fail++;
                $display("FAIL %s: got v=%0b id=%0d grants=%b, expected v=%0b id=%0d grants=%b",
                         mon_e.name, v, grant_id, grants, mon_e.v, mon_e.id, mon_g);
            end
        end

        n_tests++;
        if (!$onehot0(grants) || (grants & ~reqs) != '0) begin
            n_fail++;
            $display("FAIL grant_shape: got grants=%b reqs=%b, expected onehot0 subset", grants, reqs);
        end

        for (int k = 0; k < int'(N); k++) begin
            if (!reset_n || !reqs[k]) begin
                wait_cnt[k] = 0;
            end else if (v && yumi) begin
                if (grants[k]) begin
                    wait_cnt[k] = 0;
                end else begin
                    wait_cnt[k]++;
                    n_tests++;
                    if (wait_cnt[k] > BOUND) begin
                        n_fail++;
                        $display("FAIL starvation_bound: requester %0d waited %0d handshakes, limit %0d",
                                 k, wait_cnt[k], BOUND);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < int'(N); k++) wait_cnt[k] = 0;

        // Plain round robin with unit weights, then idle and resume.
        cur_w = 16'h1111;
        do_reset();
        drive(1'b1, 4'b1111, 1'b1, 0, "rr_0");
        drive(1'b1, 4'b1111, 1'b1, 1, "rr_1");
        drive(1'b1, 4'b1111, 1'b1, 2, "rr_2");
        drive(1'b1, 4'b1111, 1'b1, 3, "rr_3");
        drive(1'b1, 4'b1111, 1'b1, 0, "rr_wrap");
        drive(1'b1, 4'b0000, 1'b1, -1, "idle");
        drive(1'b1, 4'b1111, 1'b0, 1, "rr_resume");

        // w0=3, w2=1.
        cur_w = 16'h1113;
        do_reset();
        drive(1'b1, 4'b0101, 1'b1, 0, "wt_a0");
        drive(1'b1, 4'b0101, 1'b1, 0, "wt_a1");
        drive(1'b1, 4'b0101, 1'b1, 0, "wt_a2");
        drive(1'b1, 4'b0101, 1'b1, 2, "wt_a3");
        drive(1'b1, 4'b0101, 1'b1, 0, "wt_a4");
        drive(1'b1, 4'b0101, 1'b1, 0, "wt_a5");
        drive(1'b1, 4'b0101, 1'b1, 0, "wt_a6");
        drive(1'b1, 4'b0101, 1'b1, 2, "wt_a7");

        // Owner 1 (w=4) drops its request after two handshakes.
        cur_w = 16'h1141;
        do_reset();
        drive(1'b1, 4'b0100, 1'b1, 2, "drop_pre");
        drive(1'b1, 4'b0010, 1'b1, 1, "drop_own0");
        drive(1'b1, 4'b0010, 1'b1, 1, "drop_own1");
        drive(1'b1, 4'b1001, 1'b0, 3, "drop_grant");
        drive(1'b1, 4'b0101, 1'b0, 2, "drop_last");
        drive(1'b1, 4'b1001, 1'b1, 3, "drop_hs");
        drive(1'b1, 4'b1001, 1'b1, 0, "drop_after");

        // Stalled consumer leaves state untouched; yumi while idle is ignored.
        cur_w = 16'h1111;
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 4'b0110, 1'b0, 1, "stall");
        drive(1'b1, 4'b0110, 1'b1, 1, "stall_hs1");
        drive(1'b1, 4'b0110, 1'b1, 2, "stall_hs2");
        drive(1'b1, 4'b0000, 1'b1, -1, "yumi_idle");
        drive(1'b1, 4'b1111, 1'b0, 3, "yumi_idle_after");

        // Zero weights behave like unit weights.
        cur_w = 16'h0000;
        do_reset();
        drive(1'b1, 4'b1111, 1'b1, 0, "w0_0");
        drive(1'b1, 4'b1111, 1'b1, 1, "w0_1");
        drive(1'b1, 4'b1111, 1'b1, 2, "w0_2");
        drive(1'b1, 4'b1111, 1'b1, 3, "w0_3");
        drive(1'b1, 4'b1111, 1'b1, 0, "w0_4");

        // Reset in the middle of a turn (owner 2, 1 of 3).
        cur_w = 16'h1311;
        do_reset();
        drive(1'b1, 4'b0100, 1'b1, 2, "mid_own");
        drive(1'b0, 4'b1111, 1'b1, -2, "mid_rst");
        drive(1'b1, 4'b1111, 1'b1, 0, "mid_after0");
        drive(1'b1, 4'b1111, 1'b1, 1, "mid_after1");

        // Weight change mid-turn does not extend the running turn.
        cur_w = 16'h1112;
        do_reset();
        drive(1'b1, 4'b0011, 1'b1, 0, "wchg_0");
        cur_w = 16'h111F;
        drive(1'b1, 4'b0011, 1'b1, 0, "wchg_1");
        drive(1'b1, 4'b0011, 1'b1, 1, "wchg_2");
        drive(1'b1, 4'b0011, 1'b1, 0, "wchg_3");
        drive(1'b1, 4'b0011, 1'b1, 0, "wchg_4");

        // Maximum weights: fifteen handshakes per turn.
        cur_w = 16'hFFFF;
        do_reset();
        for (int i = 0; i < 64; i++) drive(1'b1, 4'b1111, 1'b1, (i / 15) % 4, "max_wt");

        drive(1'b1, 4'b0000, 1'b0, -1, "final_idle");
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
